// File: rtl/hex_dbg_pkg.sv
// hex_dbg_pkg: shared seven-segment glyphs, display mode encoding and nibble decoder.
`timescale 1ns/1ps
`default_nettype none
package hex_dbg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs 0..F, bit 0 = segment a ... bit 6 = segment g
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef enum logic {MODE_MANUAL = 1'b0, MODE_AUTO = 1'b1} mode_e;

  function automatic logic [6:0] seg_of(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage
`default_nettype wire

// File: rtl/hex_debug_mux_step_debounce.sv
// step_debounce: 2-FF synchroniser, stability counter and one-cycle pulse on accepted key press.
`timescale 1ns/1ps
`default_nettype none
module step_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic pulse
);

  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          stable;
  logic [CW-1:0] cnt;

  // cnt tracks consecutive samples that disagree with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      stable <= 1'b1;
      cnt    <= '0;
      pulse  <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        stable <= sync2;
        cnt    <= '0;
        pulse  <= stable;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/hex_debug_mux.sv
// hex_debug_mux: channel select / auto-scroll / freeze viewer driving W/4 seven-segment digits.
// Define LEADING_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
`timescale 1ns/1ps
`default_nettype none
module hex_debug_mux
  import hex_dbg_pkg::*;
#(
  parameter int NCH           = 8,
  parameter int W             = 16,
  parameter int DEB_CYCLES    = 500000,
  parameter int SCROLL_CYCLES = 50000000,
  localparam int DIGITS       = W / 4,
  localparam int SEL_W        = $clog2(NCH)
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic [NCH*W-1:0]      Chan_Data,
  input  logic [SEL_W-1:0]      Sel,
  input  logic                  Mode,
  input  logic                  Step_n,
  input  logic                  Freeze,
  output logic [DIGITS*7-1:0]   Hex_Segs,
  output logic [SEL_W-1:0]      Cur_Chan,
  output logic                  Step_Pulse,
  output logic                  Frozen
);

  localparam int TW = (SCROLL_CYCLES > 1) ? $clog2(SCROLL_CYCLES) : 1;
  localparam logic [TW-1:0]    TIMER_LAST = TW'(SCROLL_CYCLES - 1);
  localparam logic [SEL_W-1:0] CHAN_LAST  = SEL_W'(NCH - 1);
  localparam logic [SEL_W:0]   NCH_EXT    = (SEL_W + 1)'(NCH);

  logic [W-1:0]        chan [NCH];
  logic [W-1:0]        live_data;
  logic [W-1:0]        shown_data;
  logic [W-1:0]        snapshot;
  logic [TW-1:0]       timer;
  logic [SEL_W-1:0]    sel_clamped;
  logic [SEL_W-1:0]    chan_next;
  logic                terminal;
  logic [DIGITS*7-1:0] seg_next;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    assign chan[k] = Chan_Data[k*W +: W];
  end

  step_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_step (
    .clk   (Clock),
    .rst_n (Reset_n),
    .key_n (Step_n),
    .pulse (Step_Pulse)
  );

  always_comb begin
    live_data   = chan[Cur_Chan];
    shown_data  = Frozen ? snapshot : live_data;
    sel_clamped = ({1'b0, Sel} >= NCH_EXT) ? CHAN_LAST : Sel;
    chan_next   = (Cur_Chan == CHAN_LAST) ? '0 : Cur_Chan + 1'b1;
    terminal    = (timer == TIMER_LAST);
  end

  // A step coinciding with the terminal count still advances only once
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Cur_Chan <= '0;
      timer    <= '0;
    end else if (mode_e'(Mode) == MODE_MANUAL) begin
      Cur_Chan <= sel_clamped;
      timer    <= '0;
    end else if (Step_Pulse || terminal) begin
      Cur_Chan <= chan_next;
      timer    <= '0;
    end else begin
      timer <= timer + 1'b1;
    end
  end

  // Frozen doubles as the delayed Freeze level for rising-edge detection
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Frozen   <= 1'b0;
      snapshot <= '0;
    end else begin
      Frozen <= Freeze;
      if (Freeze && !Frozen) begin
        snapshot <= live_data;
      end
    end
  end

  always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
    logic lead_zero;
    lead_zero = 1'b1;
`endif
    seg_next = '0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
`ifdef LEADING_ZERO_BLANK_EN
      lead_zero = lead_zero && (shown_data[d*4 +: 4] == 4'h0);
      seg_next[d*7 +: 7] = (lead_zero && d != 0) ? SEG_BLANK : seg_of(shown_data[d*4 +: 4]);
`else
      seg_next[d*7 +: 7] = seg_of(shown_data[d*4 +: 4]);
`endif
    end
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Hex_Segs <= {DIGITS{SEG_BLANK}};
    end else begin
      Hex_Segs <= seg_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hex_debug_mux.sv
// tb_hex_debug_mux: scoreboard-driven bench for hex_debug_mux (NCH=4, W=16, DEB=4, SCROLL=10).
`timescale 1ns/1ps
`default_nettype none
module tb_hex_debug_mux;

  localparam int NCH    = 4;
  localparam int W      = 16;
  localparam int DIGITS = 4;
  localparam int SEL_W  = 2;

  logic                Clock = 1'b0;
  logic                Reset_n;
  logic [NCH*W-1:0]    Chan_Data;
  logic [SEL_W-1:0]    Sel;
  logic                Mode;
  logic                Step_n;
  logic                Freeze;
  logic [DIGITS*7-1:0] Hex_Segs;
  logic [SEL_W-1:0]    Cur_Chan;
  logic                Step_Pulse;
  logic                Frozen;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_v;
  logic [31:0] exp_p;

  always #5 Clock = ~Clock;

  hex_debug_mux #(
    .NCH(NCH), .W(W), .DEB_CYCLES(4), .SCROLL_CYCLES(10)
  ) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Chan_Data(Chan_Data), .Sel(Sel),
    .Mode(Mode), .Step_n(Step_n), .Freeze(Freeze), .Hex_Segs(Hex_Segs),
    .Cur_Chan(Cur_Chan), .Step_Pulse(Step_Pulse), .Frozen(Frozen)
  );

  function automatic logic [6:0] glyph(input logic [3:0] n);
    case (n)
      4'h0: glyph = 7'b1000000;  4'h1: glyph = 7'b1111001;
      4'h2: glyph = 7'b0100100;  4'h3: glyph = 7'b0110000;
      4'h4: glyph = 7'b0011001;  4'h5: glyph = 7'b0010010;
      4'h6: glyph = 7'b0000010;  4'h7: glyph = 7'b1111000;
      4'h8: glyph = 7'b0000000;  4'h9: glyph = 7'b0010000;
      4'hA: glyph = 7'b0001000;  4'hB: glyph = 7'b0000011;
      4'hC: glyph = 7'b1000110;  4'hD: glyph = 7'b0100001;
      4'hE: glyph = 7'b0000110;  default: glyph = 7'b0001110;
    endcase
  endfunction

  function automatic logic [27:0] exp_segs(input logic [15:0] v);
`ifdef LEADING_ZERO_BLANK_EN
    logic nz;
    nz = 1'b0;
`endif
    exp_segs = '0;
    for (int d = 3; d >= 0; d--) begin
      exp_segs[d*7 +: 7] = glyph(v[d*4 +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      nz = nz | (v[d*4 +: 4] != 4'h0);
      if (!nz && d != 0) exp_segs[d*7 +: 7] = 7'b1111111;
`endif
    end
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic set_chan(input int k, input logic [15:0] v);
    Chan_Data[k*W +: W] = v;
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; Chan_Data = '0; Sel = '0; Mode = 1'b0; Step_n = 1'b1; Freeze = 1'b0;
    set_chan(0, 16'h12AF);
    repeat (3) @(posedge Clock);
    #1;
    n_checks++;
    if (Hex_Segs !== 28'hFFFFFFF) begin n_fail++; $display("FAIL reset_hex: got %h want %h", Hex_Segs, 28'hFFFFFFF); end
    n_checks++;
    if (Cur_Chan !== 2'd0 || Step_Pulse !== 1'b0 || Frozen !== 1'b0) begin
      n_fail++; $display("FAIL reset_outs: got chan=%0d pulse=%b frozen=%b want 0 0 0", Cur_Chan, Step_Pulse, Frozen);
    end
    Reset_n = 1'b1;
    sb_q.push_back(32'(exp_segs(16'h12AF)));
    tick(); tick();
    exp_v = sb_q.pop_front();
    n_checks++;
    if (Hex_Segs !== exp_v[27:0]) begin n_fail++; $display("FAIL first_display: got %h want %h", Hex_Segs, exp_v[27:0]); end
  endtask

  task automatic test_manual();
    logic [20:0] hi_exp;
    set_chan(2, 16'h0008);
    Sel = 2'd2;
    sb_q.push_back(32'd2);
    sb_q.push_back(32'(exp_segs(16'h12AF)));
    tick();
    exp_v = sb_q.pop_front();
    n_checks++;
    if (Cur_Chan !== exp_v[1:0]) begin n_fail++; $display("FAIL manual_sel: got %0d want %0d", Cur_Chan, exp_v[1:0]); end
    exp_v = sb_q.pop_front();
    n_checks++;
    if (Hex_Segs !== exp_v[27:0]) begin n_fail++; $display("FAIL manual_latency: got %h want %h", Hex_Segs, exp_v[27:0]); end
    sb_q.push_back(32'(exp_segs(16'h0008)));
    tick();
    exp_v = sb_q.pop_front();
    n_checks++;
    if (Hex_Segs !== exp_v[27:0]) begin n_fail++; $display("FAIL manual_hex: got %h want %h", Hex_Segs, exp_v[27:0]); end
    n_checks++;
    if (Hex_Segs[6:0] !== 7'b0000000) begin n_fail++; $display("FAIL digit0_eight: got %b want 0000000", Hex_Segs[6:0]); end
`ifdef LEADING_ZERO_BLANK_EN
    hi_exp = {3{7'b1111111}};
`else
    hi_exp = {3{7'b1000000}};
`endif
    n_checks++;
    if (Hex_Segs[27:7] !== hi_exp) begin n_fail++; $display("FAIL upper_digits: got %h want %h", Hex_Segs[27:7], hi_exp); end
  endtask

  task automatic test_auto_scroll();
    Sel = 2'd0;
    tick();
    Mode = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      sb_q.push_back(32'((i / 10) % 4));
      tick();
      exp_v = sb_q.pop_front();
      n_checks++;
      if (Cur_Chan !== exp_v[1:0]) begin n_fail++; $display("FAIL scroll_chan[%0d]: got %0d want %0d", i, Cur_Chan, exp_v[1:0]); end
    end
  endtask

  // Bouncy press: pulse lands mid-dwell, so the advance must also restart the dwell
  task automatic test_step();
    Mode = 1'b0; Sel = 2'd1;
    tick();
    Mode = 1'b1;
    for (int j = 1; j <= 30; j++) begin
      Step_n = ((j == 4) || (j == 5) || (j >= 7 && j <= 14)) ? 1'b0 : 1'b1;
      sb_q.push_back((j < 10) ? 32'd1 : (j < 13) ? 32'd2 : (j < 23) ? 32'd3 : 32'd0);
      sb_q.push_back((j == 12) ? 32'd1 : 32'd0);
      tick();
      exp_v = sb_q.pop_front();
      exp_p = sb_q.pop_front();
      n_checks++;
      if (Cur_Chan !== exp_v[1:0]) begin n_fail++; $display("FAIL step_chan[%0d]: got %0d want %0d", j, Cur_Chan, exp_v[1:0]); end
      n_checks++;
      if (Step_Pulse !== exp_p[0]) begin n_fail++; $display("FAIL step_pulse[%0d]: got %b want %b", j, Step_Pulse, exp_p[0]); end
    end
  endtask

  task automatic test_step_coincident();
    Mode = 1'b0; Sel = 2'd0; Step_n = 1'b1;
    tick();
    Mode = 1'b1;
    for (int j = 1; j <= 22; j++) begin
      Step_n = (j >= 4 && j <= 12) ? 1'b0 : 1'b1;
      sb_q.push_back((j < 10) ? 32'd0 : (j < 20) ? 32'd1 : 32'd2);
      sb_q.push_back((j == 9) ? 32'd1 : 32'd0);
      tick();
      exp_v = sb_q.pop_front();
      exp_p = sb_q.pop_front();
      n_checks++;
      if (Cur_Chan !== exp_v[1:0]) begin n_fail++; $display("FAIL coinc_chan[%0d]: got %0d want %0d", j, Cur_Chan, exp_v[1:0]); end
      n_checks++;
      if (Step_Pulse !== exp_p[0]) begin n_fail++; $display("FAIL coinc_pulse[%0d]: got %b want %b", j, Step_Pulse, exp_p[0]); end
    end
  endtask

  task automatic test_freeze();
    Mode = 1'b0; Sel = 2'd1; Step_n = 1'b1;
    set_chan(1, 16'hBEEF);
    tick(); tick();
    n_checks++;
    if (Hex_Segs !== exp_segs(16'hBEEF)) begin n_fail++; $display("FAIL freeze_live: got %h want %h", Hex_Segs, exp_segs(16'hBEEF)); end
    Freeze = 1'b1;
    tick();
    n_checks++;
    if (Frozen !== 1'b1) begin n_fail++; $display("FAIL frozen_set: got %b want 1", Frozen); end
    set_chan(1, 16'h0000);
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(32'(exp_segs(16'hBEEF)));
      tick();
      exp_v = sb_q.pop_front();
      n_checks++;
      if (Hex_Segs !== exp_v[27:0] || Frozen !== 1'b1) begin
        n_fail++; $display("FAIL freeze_hold[%0d]: got %h/%b want %h/1", i, Hex_Segs, Frozen, exp_v[27:0]);
      end
    end
    Freeze = 1'b0;
    tick();
    n_checks++;
    if (Frozen !== 1'b0) begin n_fail++; $display("FAIL frozen_clear: got %b want 0", Frozen); end
    sb_q.push_back(32'(exp_segs(16'h0000)));
    tick();
    exp_v = sb_q.pop_front();
    n_checks++;
    if (Hex_Segs !== exp_v[27:0]) begin n_fail++; $display("FAIL unfreeze_live: got %h want %h", Hex_Segs, exp_v[27:0]); end
  endtask

  task automatic test_async_reset();
    set_chan(0, 16'h12AF);
    Mode = 1'b1; Freeze = 1'b1;
    repeat (15) tick();
    n_checks++;
    if (Frozen !== 1'b1 || Cur_Chan !== 2'd2) begin
      n_fail++; $display("FAIL pre_reset: got frozen=%b chan=%0d want 1 2", Frozen, Cur_Chan);
    end
    #2;
    Reset_n = 1'b0;
    #1;
    n_checks++;
    if (Cur_Chan !== 2'd0 || Frozen !== 1'b0 || Step_Pulse !== 1'b0 || Hex_Segs !== 28'hFFFFFFF) begin
      n_fail++; $display("FAIL async_reset: got chan=%0d frozen=%b pulse=%b hex=%h want 0 0 0 fffffff",
                         Cur_Chan, Frozen, Step_Pulse, Hex_Segs);
    end
    Mode = 1'b0; Sel = 2'd0;
    tick();
    Reset_n = 1'b1;
    tick();
    n_checks++;
    if (Frozen !== 1'b1) begin n_fail++; $display("FAIL freeze_thru_reset: got %b want 1", Frozen); end
    set_chan(0, 16'h0000);
    sb_q.push_back(32'(exp_segs(16'h12AF)));
    tick();
    exp_v = sb_q.pop_front();
    n_checks++;
    if (Hex_Segs !== exp_v[27:0]) begin n_fail++; $display("FAIL snapshot_after_reset: got %h want %h", Hex_Segs, exp_v[27:0]); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got still running want finished");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_manual();
    test_auto_scroll();
    test_step();
    test_step_coincident();
    test_freeze();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
